// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a synchronous single-port RAM: sequences write/read bursts from commands.
// Latency: write hits RAM in the wr handshake cycle; read word reaches rd_data 2 cycles after issue.
// Backpressure: cmd_ready only when idle, wr_ready only in WRITE, RAM reads throttled by 2-entry out FIFO.
//
// Ports: clk/rst (sync, active-high); cmd_* burst command stream (wr, start addr, len = words-1);
//        wr_* write-data stream; rd_* read-data stream; busy/done status; ram_* RAM port.
// Optional: define RAM_CTRL_CSUM_EN to add output csum = XOR of the words moved in the current burst.
module ram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_CTRL_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LEN_W:0]    CNT_ONE  = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;   // next RAM address to access
    logic [ADDR_W-1:0] addr_hold;  // last address driven, shown on ram_addr when not accessing
    logic [LEN_W:0]    iss_cnt;    // RAM accesses still to issue
    logic [LEN_W:0]    rd_cnt;     // read words still to hand to the consumer
    logic              inflight;   // read issued last cycle, ram_dout valid now
    logic [1:0]        occ;        // out FIFO occupancy; rd_data is the head entry
    logic [DATA_W-1:0] fifo_tail;  // second FIFO entry
    logic              done_q;

    logic cmd_hs, wr_hs, rd_hs, rd_issue, finish;

    assign rd_valid = (occ != 2'd0);
    assign rd_hs    = rd_valid & rd_ready;
    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign ram_we   = wr_hs;
    assign ram_din  = wr_data;
    assign ram_addr = (wr_hs | rd_issue) ? cur_addr : addr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cmd_hs    = 1'b0;
        wr_ready  = 1'b0;
        wr_hs     = 1'b0;
        rd_issue  = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_hs    = 1'b1;
                    state_nxt = cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                wr_hs    = wr_valid;
                if (wr_valid && iss_cnt == CNT_ONE) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                // Stored plus in-flight words must fit in the FIFO; a pop this cycle frees a slot.
                rd_issue = (iss_cnt != '0) &&
                           (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, rd_hs}));
                if (rd_hs && rd_cnt == CNT_ONE) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            addr_hold <= '0;
            iss_cnt   <= '0;
            rd_cnt    <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            rd_data   <= '0;
            fifo_tail <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= finish;
            inflight <= rd_issue;

            if (cmd_hs) begin
                cur_addr <= cmd_addr;
                iss_cnt  <= {1'b0, cmd_len} + CNT_ONE;
                rd_cnt   <= {1'b0, cmd_len} + CNT_ONE;
            end else begin
                if (wr_hs || rd_issue) begin
                    cur_addr  <= cur_addr + ADDR_ONE;  // wraps modulo 2^ADDR_W
                    addr_hold <= cur_addr;
                    iss_cnt   <= iss_cnt - CNT_ONE;
                end
                if (rd_hs) begin
                    rd_cnt <= rd_cnt - CNT_ONE;
                end
            end

            // Push = word returning from RAM. The issue throttle guarantees no push when full.
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        rd_data <= ram_dout;
                        occ     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && rd_hs) begin
                        rd_data <= ram_dout;
                    end else if (inflight) begin
                        fifo_tail <= ram_dout;
                        occ       <= 2'd2;
                    end else if (rd_hs) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: begin
                    if (rd_hs) begin
                        rd_data <= fifo_tail;
                        occ     <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

`ifdef RAM_CTRL_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst || cmd_hs) begin
            csum <= '0;
        end else if (wr_hs) begin
            csum <= csum ^ wr_data;
        end else if (rd_hs) begin
            csum <= csum ^ rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done, ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
`ifdef RAM_CTRL_CSUM_EN
    logic [7:0] csum;
`endif

    ram_burst_ctrl #(.DATA_W(8), .ADDR_W(7), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_CTRL_CSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered read.
    logic [7:0] mem [0:127];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [6:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_rd [$];

    logic [7:0] wdat [0:7];
    int         gap  [0:7];
    bit         offer_next = 1'b0;
    logic [6:0] nxt_addr;
    logic [7:0] nxt_len;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: RAM writes, read-stream handshakes, done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (exp_wa.size() == 0) begin
                    chk("ram_we_unexpected", 1, 0);
                end else begin
                    chk("ram_addr", ram_addr, exp_wa.pop_front());
                    chk("ram_din", ram_din, exp_wd.pop_front());
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic send_cmd(input logic wr, input logic [6:0] a, input logic [7:0] l, input bit pre);
        bit ok;
        if (!pre) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
            ok = 1'b0;
            for (int n = 0; n < 50 && !ok; n++) begin
                @(negedge clk);
                ok = cmd_ready;
                if (!ok) begin @(posedge clk); #1; end
            end
            chk("cmd_accept", ok, 1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] l);
        send_cmd(1'b1, a, l, 1'b0);
        if (offer_next) begin
            cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = nxt_addr; cmd_len = nxt_len;
        end
        for (int i = 0; i <= int'(l); i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                wr_valid = 1'b0;
                @(negedge clk);
                chk("we_in_gap", ram_we, 0);
                if (offer_next) chk("cmd_blocked", cmd_ready, 0);
                @(posedge clk); #1;
            end
            exp_wa.push_back(a + 7'(i));
            exp_wd.push_back(wdat[i]);
            wr_valid = 1'b1; wr_data = wdat[i];
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            if (offer_next) chk("cmd_blocked", cmd_ready, 0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_busy_after", busy, 0);
        exp_done++;
        if (offer_next) chk("cmd_ready_at_done", cmd_ready, 1);
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready toggles 1,0,1,0...
    task automatic do_read(input logic [6:0] a, input logic [7:0] l, input bit pre, input int mode);
        int hs = 0;
        int k = 0;
        bit stall = 1'b0;
        logic [7:0] pdat = '0;
        send_cmd(1'b0, a, l, pre);
        while (hs < int'(l) + 1 && k < 400) begin
            rd_ready = (mode == 0) ? 1'b1 : ((k % 2) == 0);
            @(negedge clk);
            if (stall) begin
                chk("rd_hold_valid", rd_valid, 1);
                chk("rd_hold_data", rd_data, pdat);
            end
            stall = rd_valid && !rd_ready;
            pdat = rd_data;
            if (rd_valid && rd_ready) hs++;
            k++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        chk("rd_word_count", hs, int'(l) + 1);
        if (mode == 0) chk("rd_cycles_full_rate", k, int'(l) + 3);
        @(negedge clk);
        chk("rd_done", done, 1);
        chk("rd_busy_after", busy, 0);
        exp_done++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) gap[i] = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: write 0x10 A0..A3, read back at full rate
        wdat[0] = 8'hA0; wdat[1] = 8'hA1; wdat[2] = 8'hA2; wdat[3] = 8'hA3;
        do_write(7'h10, 8'd3);
        exp_rd.push_back(8'hA0); exp_rd.push_back(8'hA1);
        exp_rd.push_back(8'hA2); exp_rd.push_back(8'hA3);
        do_read(7'h10, 8'd3, 1'b0, 0);
        chk("ram_addr_hold_after_read", ram_addr, 7'h13);

        // 3: write across the address wrap 0x7E,0x7F,0x00,0x01
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        do_write(7'h7E, 8'd3);
        chk("ram_addr_hold_idle", ram_addr, 7'h01);

        // 4: write with wr_valid gaps while the next read command waits
        wdat[0] = 8'h55; wdat[1] = 8'h66; wdat[2] = 8'h77; wdat[3] = 8'h88;
        gap[1] = 2; gap[3] = 1;
        offer_next = 1'b1; nxt_addr = 7'h7E; nxt_len = 8'd7;
        do_write(7'h02, 8'd3);
        offer_next = 1'b0;
        for (int i = 0; i < 8; i++) gap[i] = 0;

        // 2: the waiting read (len 7 from 0x7E) with rd_ready toggling
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
        exp_rd.push_back(8'h55); exp_rd.push_back(8'h66);
        exp_rd.push_back(8'h77); exp_rd.push_back(8'h88);
        do_read(7'h7E, 8'd7, 1'b1, 1);

        // 5: reset after two words of a read burst
        begin
            int hs = 0;
            int k = 0;
            exp_rd.push_back(8'hA0); exp_rd.push_back(8'hA1);
            send_cmd(1'b0, 7'h10, 8'd7, 1'b0);
            rd_ready = 1'b1;
            while (hs < 2 && k < 50) begin
                @(negedge clk);
                if (rd_valid && rd_ready) hs++;
                k++;
                @(posedge clk); #1;
            end
            chk("rst_test_words", hs, 2);
            rd_ready = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("midrst_rd_valid", rd_valid, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_cmd_ready", cmd_ready, 1);
            chk("midrst_ram_we", ram_we, 0);
            chk("midrst_done", done, 0);
        end
        wdat[0] = 8'h5A; wdat[1] = 8'h5B;
        do_write(7'h20, 8'd1);
        exp_rd.push_back(8'h5A); exp_rd.push_back(8'h5B);
        do_read(7'h20, 8'd1, 1'b0, 0);

`ifdef RAM_CTRL_CSUM_EN
        // 6: checksum over write and read-back bursts
        wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h04; wdat[3] = 8'h08;
        do_write(7'h30, 8'd3);
        chk("csum_write", csum, 8'h0F);
        exp_rd.push_back(8'h01); exp_rd.push_back(8'h02);
        exp_rd.push_back(8'h04); exp_rd.push_back(8'h08);
        do_read(7'h30, 8'd3, 1'b0, 0);
        chk("csum_read", csum, 8'h0F);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_pulse_total", done_cnt, exp_done);
        chk("exp_wr_left", exp_wa.size(), 0);
        chk("exp_rd_left", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
